rx_app_read_ctrl: RTL and testbench

- App-side consumer of the per-flow RX payload indices: the reader/drainer to the index store's writer.
- Accepts application read requests (flow, max bytes) and reads that flow's head and commit indices.
- Computes the readable byte count, issues one payload-buffer read, advances the head index, then returns the granted length to the app.
- Sits between the app interface and the RX index store (rd1 ports of head/commit, head write port) and the RX payload buffer.

---
 rtl/rx_app_read_ctrl_pkg.sv | 38 +++
 rtl/rx_app_read_ctrl_if.sv | 75 +++++++
 rtl/rx_app_read_ctrl_datap.sv | 91 +++++++++
 rtl/rx_app_read_ctrl.sv | 142 ++++++++++++++
 tb/tb_rx_app_read_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_app_read_ctrl_pkg.sv
// Shared types for the RX application read controller: FSM states and
// default-width request/response records for the standard tcp configuration.
package rx_app_read_ctrl_pkg;

  localparam int FLOWID_W_DEF = 8;
  localparam int IDX_W_DEF    = 16;
  localparam int LEN_W_DEF    = 16;

  // Stored payload index: IDX_W offset bits plus one wrap bit.
  typedef logic [IDX_W_DEF:0] tcp_buf_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_META_REQ,
    ST_META_RESP,
    ST_CALC,
    ST_BUF_REQ,
    ST_HEAD_WR,
    ST_APP_RESP
  } rd_state_e;

  typedef struct packed {
    logic [FLOWID_W_DEF-1:0] flowid;
    logic [LEN_W_DEF-1:0]    len;
  } rx_app_rd_req_t;

  typedef struct packed {
    logic [FLOWID_W_DEF-1:0] flowid;
    logic [LEN_W_DEF-1:0]    len;
  } rx_app_rd_resp_t;

  typedef struct packed {
    logic [FLOWID_W_DEF-1:0] flowid;
    logic [IDX_W_DEF-1:0]    offset;
    logic [LEN_W_DEF-1:0]    len;
  } buf_rd_req_t;

endpackage

// File: rtl/rx_app_read_ctrl_if.sv
// Bundle of every handshake channel around the read controller; master is
// the controller side, slave is the app / index store / payload buffer side.
interface rx_app_read_ctrl_if
  import rx_app_read_ctrl_pkg::*;
#(
  parameter int FLOWID_W = FLOWID_W_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int LEN_W    = LEN_W_DEF
);
  logic                app_rd_req_val;
  logic [FLOWID_W-1:0] app_rd_req_flowid;
  logic [LEN_W-1:0]    app_rd_req_len;
  logic                app_rd_req_rdy;

  logic                head_rd_req_val;
  logic [FLOWID_W-1:0] head_rd_req_addr;
  logic                head_rd_req_rdy;
  logic                head_rd_resp_val;
  logic [IDX_W:0]      head_rd_resp_data;
  logic                head_rd_resp_rdy;

  logic                commit_rd_req_val;
  logic [FLOWID_W-1:0] commit_rd_req_addr;
  logic                commit_rd_req_rdy;
  logic                commit_rd_resp_val;
  logic [IDX_W:0]      commit_rd_resp_data;
  logic                commit_rd_resp_rdy;

  logic                head_wr_req_val;
  logic [FLOWID_W-1:0] head_wr_req_addr;
  logic [IDX_W:0]      head_wr_req_data;
  logic                head_wr_req_rdy;

  logic                buf_rd_req_val;
  logic [FLOWID_W-1:0] buf_rd_req_flowid;
  logic [IDX_W-1:0]    buf_rd_req_offset;
  logic [LEN_W-1:0]    buf_rd_req_len;
  logic                buf_rd_req_rdy;

  logic                app_rd_resp_val;
  logic [FLOWID_W-1:0] app_rd_resp_flowid;
  logic [LEN_W-1:0]    app_rd_resp_len;
  logic                app_rd_resp_rdy;

  modport master (
    input  app_rd_req_val, app_rd_req_flowid, app_rd_req_len,
    output app_rd_req_rdy,
    output head_rd_req_val, head_rd_req_addr, head_rd_resp_rdy,
    input  head_rd_req_rdy, head_rd_resp_val, head_rd_resp_data,
    output commit_rd_req_val, commit_rd_req_addr, commit_rd_resp_rdy,
    input  commit_rd_req_rdy, commit_rd_resp_val, commit_rd_resp_data,
    output head_wr_req_val, head_wr_req_addr, head_wr_req_data,
    input  head_wr_req_rdy,
    output buf_rd_req_val, buf_rd_req_flowid, buf_rd_req_offset, buf_rd_req_len,
    input  buf_rd_req_rdy,
    output app_rd_resp_val, app_rd_resp_flowid, app_rd_resp_len,
    input  app_rd_resp_rdy
  );

  modport slave (
    output app_rd_req_val, app_rd_req_flowid, app_rd_req_len,
    input  app_rd_req_rdy,
    input  head_rd_req_val, head_rd_req_addr, head_rd_resp_rdy,
    output head_rd_req_rdy, head_rd_resp_val, head_rd_resp_data,
    input  commit_rd_req_val, commit_rd_req_addr, commit_rd_resp_rdy,
    output commit_rd_req_rdy, commit_rd_resp_val, commit_rd_resp_data,
    input  head_wr_req_val, head_wr_req_addr, head_wr_req_data,
    output head_wr_req_rdy,
    input  buf_rd_req_val, buf_rd_req_flowid, buf_rd_req_offset, buf_rd_req_len,
    output buf_rd_req_rdy,
    input  app_rd_resp_val, app_rd_resp_flowid, app_rd_resp_len,
    output app_rd_resp_rdy
  );

endinterface

// File: rtl/rx_app_read_ctrl_datap.sv
// Latched request/index registers and the readable-byte arithmetic for the
// read controller; all index math is modulo 2^(IDX_W+1).
module rx_app_read_ctrl_datap
  import rx_app_read_ctrl_pkg::*;
#(
  parameter int FLOWID_W = FLOWID_W_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                latch_req_i,
  input  logic [FLOWID_W-1:0] req_flowid_i,
  input  logic [LEN_W-1:0]    req_len_i,
  input  logic                cap_head_i,
  input  logic [IDX_W:0]      head_data_i,
  input  logic                cap_commit_i,
  input  logic [IDX_W:0]      commit_data_i,
  input  logic                calc_i,
  output logic [FLOWID_W-1:0] flowid_o,
  output logic [IDX_W:0]      head_o,
  output logic [LEN_W-1:0]    grant_o,
  output logic [IDX_W:0]      new_head_o,
  output logic                grant_zero_o
);
  localparam int CW = (LEN_W > IDX_W + 1) ? LEN_W : IDX_W + 1;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [IDX_W:0]   avail);
    logic [CW-1:0] l;
    logic [CW-1:0] a;
    l = CW'(len);
    a = CW'(avail);
    return (l < a) ? LEN_W'(l) : LEN_W'(a);
  endfunction

  logic [FLOWID_W-1:0] flowid_q, flowid_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [IDX_W:0]      head_q, head_d, commit_q, commit_d, new_head_q, new_head_d;
  logic [LEN_W-1:0]    grant_q, grant_d;
  logic [IDX_W:0]      avail;
  logic [LEN_W-1:0]    grant_calc;

  // Wrap bit makes the plain subtraction correct across the buffer wrap.
  assign avail        = commit_q - head_q;
  assign grant_calc   = clamp_len(len_q, avail);
  assign grant_zero_o = (grant_calc == '0);

  always_comb begin
    flowid_d   = flowid_q;
    len_d      = len_q;
    head_d     = head_q;
    commit_d   = commit_q;
    grant_d    = grant_q;
    new_head_d = new_head_q;
    if (latch_req_i) begin
      flowid_d = req_flowid_i;
      len_d    = req_len_i;
    end
    if (cap_head_i)   head_d   = head_data_i;
    if (cap_commit_i) commit_d = commit_data_i;
    if (calc_i) begin
      grant_d    = grant_calc;
      new_head_d = head_q + (IDX_W+1)'(grant_calc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flowid_q   <= '0;
      len_q      <= '0;
      head_q     <= '0;
      commit_q   <= '0;
      grant_q    <= '0;
      new_head_q <= '0;
    end else begin
      flowid_q   <= flowid_d;
      len_q      <= len_d;
      head_q     <= head_d;
      commit_q   <= commit_d;
      grant_q    <= grant_d;
      new_head_q <= new_head_d;
    end
  end

  assign flowid_o   = flowid_q;
  assign head_o     = head_q;
  assign grant_o    = grant_q;
  assign new_head_o = new_head_q;

endmodule

// File: rtl/rx_app_read_ctrl.sv
// RX app read controller: reads a flow's head/commit indices, issues one
// payload read for the available bytes, advances head, then completes to the app.
module rx_app_read_ctrl
  import rx_app_read_ctrl_pkg::*;
#(
  parameter int FLOWID_W = FLOWID_W_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input logic                clk,
  input logic                rst,
  rx_app_read_ctrl_if.master bus
);
  rd_state_e state_q, state_d;
  logic hsent_q, hsent_d, csent_q, csent_d, hcap_q, hcap_d, ccap_q, ccap_d;
  logic req_rdy, hreq_val, creq_val, hresp_rdy, cresp_rdy;
  logic hwr_val, buf_val, resp_val;
  logic cap_head, cap_commit, latch_req, calc, grant_zero;
  logic [FLOWID_W-1:0] flowid;
  logic [IDX_W:0]      head, new_head;
  logic [LEN_W-1:0]    grant;

  // Responses are accepted as soon as their request has gone out, so a
  // channel that handshakes early is not held waiting for the other one.
  assign hresp_rdy  = (state_q == ST_META_RESP) || ((state_q == ST_META_REQ) && hsent_q);
  assign cresp_rdy  = (state_q == ST_META_RESP) || ((state_q == ST_META_REQ) && csent_q);
  assign cap_head   = bus.head_rd_resp_val && hresp_rdy && !hcap_q;
  assign cap_commit = bus.commit_rd_resp_val && cresp_rdy && !ccap_q;

  always_comb begin
    state_d   = state_q;
    hsent_d   = hsent_q;
    csent_d   = csent_q;
    hcap_d    = hcap_q || cap_head;
    ccap_d    = ccap_q || cap_commit;
    req_rdy   = 1'b0;
    hreq_val  = 1'b0;
    creq_val  = 1'b0;
    hwr_val   = 1'b0;
    buf_val   = 1'b0;
    resp_val  = 1'b0;
    latch_req = 1'b0;
    calc      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_rdy = 1'b1;
        hsent_d = 1'b0;
        csent_d = 1'b0;
        hcap_d  = 1'b0;
        ccap_d  = 1'b0;
        if (bus.app_rd_req_val) begin
          latch_req = 1'b1;
          state_d   = ST_META_REQ;
        end
      end
      ST_META_REQ: begin
        hreq_val = !hsent_q;
        creq_val = !csent_q;
        if (hreq_val && bus.head_rd_req_rdy)   hsent_d = 1'b1;
        if (creq_val && bus.commit_rd_req_rdy) csent_d = 1'b1;
        if (hsent_d && csent_d) state_d = ST_META_RESP;
      end
      ST_META_RESP: if (hcap_d && ccap_d) state_d = ST_CALC;
      ST_CALC: begin
        calc    = 1'b1;
        state_d = grant_zero ? ST_APP_RESP : ST_BUF_REQ;
      end
      // Payload read goes out before the head moves so freed space is not reused early.
      ST_BUF_REQ: begin
        buf_val = 1'b1;
        if (bus.buf_rd_req_rdy) state_d = ST_HEAD_WR;
      end
      ST_HEAD_WR: begin
        hwr_val = 1'b1;
        if (bus.head_wr_req_rdy) state_d = ST_APP_RESP;
      end
      ST_APP_RESP: begin
        resp_val = 1'b1;
        if (bus.app_rd_resp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hsent_q <= 1'b0;
      csent_q <= 1'b0;
      hcap_q  <= 1'b0;
      ccap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hsent_q <= hsent_d;
      csent_q <= csent_d;
      hcap_q  <= hcap_d;
      ccap_q  <= ccap_d;
    end
  end

  rx_app_read_ctrl_datap #(
    .FLOWID_W(FLOWID_W),
    .IDX_W   (IDX_W),
    .LEN_W   (LEN_W)
  ) u_datap (
    .clk          (clk),
    .rst          (rst),
    .latch_req_i  (latch_req),
    .req_flowid_i (bus.app_rd_req_flowid),
    .req_len_i    (bus.app_rd_req_len),
    .cap_head_i   (cap_head),
    .head_data_i  (bus.head_rd_resp_data),
    .cap_commit_i (cap_commit),
    .commit_data_i(bus.commit_rd_resp_data),
    .calc_i       (calc),
    .flowid_o     (flowid),
    .head_o       (head),
    .grant_o      (grant),
    .new_head_o   (new_head),
    .grant_zero_o (grant_zero)
  );

  // Handshake outputs are forced low for the whole reset cycle.
  assign bus.app_rd_req_rdy     = req_rdy & ~rst;
  assign bus.head_rd_req_val    = hreq_val & ~rst;
  assign bus.head_rd_req_addr   = flowid;
  assign bus.head_rd_resp_rdy   = hresp_rdy & ~rst;
  assign bus.commit_rd_req_val  = creq_val & ~rst;
  assign bus.commit_rd_req_addr = flowid;
  assign bus.commit_rd_resp_rdy = cresp_rdy & ~rst;
  assign bus.head_wr_req_val    = hwr_val & ~rst;
  assign bus.head_wr_req_addr   = flowid;
  assign bus.head_wr_req_data   = new_head;
  assign bus.buf_rd_req_val     = buf_val & ~rst;
  assign bus.buf_rd_req_flowid  = flowid;
  assign bus.buf_rd_req_offset  = head[IDX_W-1:0];
  assign bus.buf_rd_req_len     = grant;
  assign bus.app_rd_resp_val    = resp_val & ~rst;
  assign bus.app_rd_resp_flowid = flowid;
  assign bus.app_rd_resp_len    = grant;

endmodule

// File: tb/tb_rx_app_read_ctrl.sv
// Bench for rx_app_read_ctrl: index store / buffer / app models around the DUT,
// expected grants computed from head/commit snapshots with plain modular arithmetic.
module tb_rx_app_read_ctrl;
  import rx_app_read_ctrl_pkg::*;

  localparam int FW   = 8;
  localparam int IW   = 4;
  localparam int LW   = 16;
  localparam int NF   = 4;
  localparam int IMOD = 1 << (IW + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_app_read_ctrl_if #(.FLOWID_W(FW), .IDX_W(IW), .LEN_W(LW)) bus ();

  rx_app_read_ctrl #(.FLOWID_W(FW), .IDX_W(IW), .LEN_W(LW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Index store: per-flow head/commit, one-cycle read latency, response held until accepted.
  int head_mem[NF];
  int commit_mem[NF];
  logic hpend = 1'b0, cpend = 1'b0;
  logic [IW:0] hdata = '0, cdata = '0;
  logic pre_val = 1'b0;
  int pre_flow = 0, pre_head = 0, pre_commit = 0;

  int n_buf = 0, n_hw = 0, n_resp = 0, n_hrd = 0, n_crd = 0, hw_buf_cnt = 0;
  logic [31:0] last_buf_flow = '0, last_buf_off = '0, last_buf_len = '0;
  logic [31:0] last_hw_addr = '0, last_hw_data = '0;

  assign bus.head_rd_resp_val    = hpend;
  assign bus.head_rd_resp_data   = hdata;
  assign bus.commit_rd_resp_val  = cpend;
  assign bus.commit_rd_resp_data = cdata;

  always @(posedge clk) begin
    if (pre_val) begin
      head_mem[pre_flow]   <= pre_head;
      commit_mem[pre_flow] <= pre_commit;
    end
    if (rst) begin
      hpend <= 1'b0;
      cpend <= 1'b0;
    end else begin
      if (hpend && bus.head_rd_resp_rdy) hpend <= 1'b0;
      if (cpend && bus.commit_rd_resp_rdy) cpend <= 1'b0;
      if (bus.head_rd_req_val && bus.head_rd_req_rdy) begin
        hpend <= 1'b1;
        hdata <= (IW+1)'(head_mem[int'(bus.head_rd_req_addr[1:0])]);
        n_hrd <= n_hrd + 1;
      end
      if (bus.commit_rd_req_val && bus.commit_rd_req_rdy) begin
        cpend <= 1'b1;
        cdata <= (IW+1)'(commit_mem[int'(bus.commit_rd_req_addr[1:0])]);
        n_crd <= n_crd + 1;
      end
      if (bus.buf_rd_req_val && bus.buf_rd_req_rdy) begin
        n_buf         <= n_buf + 1;
        last_buf_flow <= 32'(bus.buf_rd_req_flowid);
        last_buf_off  <= 32'(bus.buf_rd_req_offset);
        last_buf_len  <= 32'(bus.buf_rd_req_len);
      end
      if (bus.head_wr_req_val && bus.head_wr_req_rdy) begin
        head_mem[int'(bus.head_wr_req_addr[1:0])] <= int'(bus.head_wr_req_data);
        n_hw         <= n_hw + 1;
        hw_buf_cnt   <= n_buf;
        last_hw_addr <= 32'(bus.head_wr_req_addr);
        last_hw_data <= 32'(bus.head_wr_req_data);
      end
      if (bus.app_rd_resp_val && bus.app_rd_resp_rdy) n_resp <= n_resp + 1;
    end
  end

  task automatic preload(input int f, input int h, input int c);
    @(negedge clk);
    pre_val = 1'b1; pre_flow = f; pre_head = h; pre_commit = c;
    @(negedge clk);
    pre_val = 1'b0;
  endtask

  task automatic set_all_rdy(input bit v);
    bus.head_rd_req_rdy   = v;
    bus.commit_rd_req_rdy = v;
    bus.head_wr_req_rdy   = v;
    bus.buf_rd_req_rdy    = v;
    bus.app_rd_resp_rdy   = v;
  endtask

  task automatic send_req(input int f, input int len);
    int w;
    @(negedge clk);
    bus.app_rd_req_val    = 1'b1;
    bus.app_rd_req_flowid = FW'(f);
    bus.app_rd_req_len    = LW'(len);
    w = 0;
    while (!bus.app_rd_req_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_accept", 32'(bus.app_rd_req_rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.app_rd_req_val = 1'b0;
  endtask

  // One full transaction; expected values come from the flow's stored indices.
  task automatic run_txn(input int f, input int len, input int hst, input int wst,
                         input bit rnd, input int exp_lat);
    int h, c, avail, grant, nh, b0, w0, r0, hr0, cr0, lat, hc, wc;
    bit done, pb_stall, pw_stall, pr_stall;
    logic [31:0] pb_off, pb_len, pw_data, pr_len;
    h = head_mem[f];
    c = commit_mem[f];
    avail = (c - h + IMOD) % IMOD;
    assert (avail <= (1 << IW)) else $error("illegal index state on flow %0d", f);
    grant = (len < avail) ? len : avail;
    nh = (h + grant) % IMOD;
    b0 = n_buf; w0 = n_hw; r0 = n_resp; hr0 = n_hrd; cr0 = n_crd;
    hc = hst; wc = wst;
    done = 1'b0; lat = 0;
    pb_stall = 1'b0; pw_stall = 1'b0; pr_stall = 1'b0;
    pb_off = '0; pb_len = '0; pw_data = '0; pr_len = '0;
    send_req(f, len);
    for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
      if (pb_stall) begin
        chk("buf_off_hold", 32'(bus.buf_rd_req_offset), pb_off);
        chk("buf_len_hold", 32'(bus.buf_rd_req_len), pb_len);
      end
      if (pw_stall) chk("hw_data_hold", 32'(bus.head_wr_req_data), pw_data);
      if (pr_stall) chk("resp_len_hold", 32'(bus.app_rd_resp_len), pr_len);
      bus.head_rd_req_rdy = (hc == 0) && (!rnd || ($urandom_range(0, 3) != 0));
      if (bus.head_rd_req_val && hc > 0) hc--;
      bus.commit_rd_req_rdy = !rnd || ($urandom_range(0, 3) != 0);
      bus.head_wr_req_rdy = (wc == 0) && (!rnd || ($urandom_range(0, 3) != 0));
      if (bus.head_wr_req_val && wc > 0) wc--;
      bus.buf_rd_req_rdy  = !rnd || ($urandom_range(0, 3) != 0);
      bus.app_rd_resp_rdy = !rnd || ($urandom_range(0, 3) != 0);
      if (bus.head_wr_req_val && !bus.head_wr_req_rdy)
        chk("resp_before_hw", 32'(bus.app_rd_resp_val), 32'd0);
      pb_stall = bus.buf_rd_req_val && !bus.buf_rd_req_rdy;
      pb_off   = 32'(bus.buf_rd_req_offset);
      pb_len   = 32'(bus.buf_rd_req_len);
      pw_stall = bus.head_wr_req_val && !bus.head_wr_req_rdy;
      pw_data  = 32'(bus.head_wr_req_data);
      pr_stall = bus.app_rd_resp_val && !bus.app_rd_resp_rdy;
      pr_len   = 32'(bus.app_rd_resp_len);
      if (bus.app_rd_resp_val && bus.app_rd_resp_rdy) begin
        done = 1'b1;
        lat  = cyc;
        chk("resp_flow", 32'(bus.app_rd_resp_flowid), 32'(f));
        chk("resp_len", 32'(bus.app_rd_resp_len), 32'(grant));
      end
      @(negedge clk);
    end
    set_all_rdy(1'b1);
    chk("resp_done", 32'(done), 32'd1);
    if (exp_lat >= 0) chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_cnt", 32'(n_resp - r0), 32'd1);
    chk("head_rd_cnt", 32'(n_hrd - hr0), 32'd1);
    chk("commit_rd_cnt", 32'(n_crd - cr0), 32'd1);
    chk("buf_cnt", 32'(n_buf - b0), (grant > 0) ? 32'd1 : 32'd0);
    chk("hw_cnt", 32'(n_hw - w0), (grant > 0) ? 32'd1 : 32'd0);
    if (grant > 0) begin
      chk("buf_flow", last_buf_flow, 32'(f));
      chk("buf_off", last_buf_off, 32'(h % (1 << IW)));
      chk("buf_len", last_buf_len, 32'(grant));
      chk("hw_addr", last_hw_addr, 32'(f));
      chk("hw_data", last_hw_data, 32'(nh));
      chk("hw_after_buf", 32'(hw_buf_cnt), 32'(b0 + 1));
    end
    chk("head_mem", 32'(head_mem[f]), 32'(nh));
  endtask

  initial begin
    int w, f, h, a, len;
    rst = 1'b1;
    bus.app_rd_req_val    = 1'b0;
    bus.app_rd_req_flowid = '0;
    bus.app_rd_req_len    = '0;
    set_all_rdy(1'b1);
    for (int i = 0; i < NF; i++) preload(i, 0, 0);
    @(negedge clk);
    chk("rst_req_rdy", 32'(bus.app_rd_req_rdy), 32'd0);
    chk("rst_vals", 32'({bus.head_rd_req_val, bus.commit_rd_req_val, bus.head_wr_req_val,
                         bus.buf_rd_req_val, bus.app_rd_resp_val}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_rdy", 32'(bus.app_rd_req_rdy), 32'd1);

    preload(0, 0, 10);  run_txn(0, 6, 0, 0, 1'b0, 6);
    preload(1, 12, 20); run_txn(1, 8, 0, 0, 1'b0, 6);
    run_txn(1, 8, 0, 0, 1'b0, 4);
    preload(2, 3, 3);   run_txn(2, 5, 0, 0, 1'b0, 4);
    preload(3, 30, 2);  run_txn(3, 9, 0, 0, 1'b0, 6);
    preload(0, 4, 9);   run_txn(0, 0, 0, 0, 1'b0, 4);
    preload(1, 7, 15);  run_txn(1, 5, 3, 0, 1'b0, -1);
    run_txn(1, 10, 0, 5, 1'b0, -1);
    preload(2, 0, 16);  run_txn(2, 20, 0, 0, 1'b0, 6);

    // Reset while the payload read is stalled.
    preload(2, 5, 12);
    bus.buf_rd_req_rdy = 1'b0;
    send_req(2, 4);
    w = 0;
    while (!bus.buf_rd_req_val && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("reach_buf_req", 32'(bus.buf_rd_req_val), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_req_rdy", 32'(bus.app_rd_req_rdy), 32'd0);
    chk("midrst_buf_val", 32'(bus.buf_rd_req_val), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_req_rdy", 32'(bus.app_rd_req_rdy), 32'd1);
    chk("postrst_vals", 32'({bus.head_rd_req_val, bus.commit_rd_req_val, bus.head_wr_req_val,
                             bus.buf_rd_req_val, bus.app_rd_resp_val}), 32'd0);
    chk("postrst_head", 32'(head_mem[2]), 32'd5);
    bus.buf_rd_req_rdy = 1'b1;
    run_txn(2, 4, 0, 0, 1'b0, 6);

    for (int i = 0; i < 40; i++) begin
      f   = int'($urandom_range(0, NF - 1));
      h   = int'($urandom_range(0, IMOD - 1));
      a   = int'($urandom_range(0, 1 << IW));
      len = int'($urandom_range(0, 20));
      preload(f, h, (h + a) % IMOD);
      run_txn(f, len, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
